// File: rtl/cache_ctrl_param_if.sv
// Bundles the MEM-stage, SRAM and cache-array signals of cache_ctrl_param.
// The master modport is the controller; slave is everything around it.
interface cache_ctrl_param_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int CNT_W      = 16
);
  logic [ADDR_W-1:0]            addr;
  logic [DATA_W-1:0]            wdata;
  logic                         mem_r_en;
  logic                         mem_w_en;
  logic [DATA_W-1:0]            rdata;
  logic                         ready;
  logic [ADDR_W-1:0]            sram_addr;
  logic [DATA_W-1:0]            sram_wdata;
  logic                         sram_req;
  logic                         sram_we;
  logic [DATA_W*LINE_WORDS-1:0] sram_rdata;
  logic                         sram_ready;
  logic [ADDR_W-1:0]            cache_addr;
  logic                         cache_r_en;
  logic                         cache_hit;
  logic [DATA_W-1:0]            cache_rdata;
  logic                         cache_w_en;
  logic [DATA_W*LINE_WORDS-1:0] cache_fill;
  logic                         cache_upd_en;
  logic [DATA_W-1:0]            cache_wdata;
  logic                         cache_invalidate;
  logic [CNT_W-1:0]             hit_cnt;
  logic [CNT_W-1:0]             miss_cnt;

  modport master (
    input  addr, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready, cache_hit, cache_rdata,
    output rdata, ready, sram_addr, sram_wdata, sram_req, sram_we, cache_addr, cache_r_en,
           cache_w_en, cache_fill, cache_upd_en, cache_wdata, cache_invalidate, hit_cnt, miss_cnt
  );

  modport slave (
    output addr, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready, cache_hit, cache_rdata,
    input  rdata, ready, sram_addr, sram_wdata, sram_req, sram_we, cache_addr, cache_r_en,
           cache_w_en, cache_fill, cache_upd_en, cache_wdata, cache_invalidate, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl_param.sv
// Write-through, read-allocate cache controller between the MEM stage and the SRAM controller.
// Interface parameters must match the DATA_W/ADDR_W/LINE_WORDS/CNT_W given here.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; captures addr/wdata/op
// S_LOOKUP | one-cycle cache lookup, statistics update, write-hit strobe
// S_FILL   | line read from SRAM until sram_ready, then fill + rdata
// S_WRITE  | write-through to SRAM until sram_ready
// S_DONE   | ready for one cycle
module cache_ctrl_param #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LINE_WORDS   = 2,
  parameter int WRITE_POLICY = 0,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  cache_ctrl_param_if.master  bus
);
  localparam int BYTE_B = $clog2(DATA_W / 8);
  localparam int OFF_B  = $clog2(LINE_WORDS);
  localparam int LOW_B  = BYTE_B + OFF_B;
  localparam int IDX_W  = (OFF_B > 0) ? OFF_B : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << LOW_B) - 64'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_DONE} state_t;

  state_t             state;
  state_t             state_nx;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               write_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   hit_q;
  logic [CNT_W-1:0]   miss_q;
  logic [IDX_W-1:0]   word_idx;
  logic [DATA_W-1:0]  fill_word;
  logic               req;
  logic               ready_c;
  logic               cache_r_en_c;
  logic               cache_w_en_c;
  logic               cache_upd_en_c;
  logic               cache_inv_c;
  logic               sram_req_c;
  logic               sram_we_c;
  logic [ADDR_W-1:0]  sram_addr_c;

  generate
    if (OFF_B > 0) begin : g_idx
      assign word_idx = addr_q[BYTE_B +: OFF_B];
    end else begin : g_no_idx
      assign word_idx = '0;
    end
  endgenerate

  assign fill_word = bus.sram_rdata[int'(word_idx) * DATA_W +: DATA_W];
  assign req       = bus.mem_r_en | bus.mem_w_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        write_q <= ~bus.mem_r_en;  // a read wins when both enables are set
      end
      if (state == S_LOOKUP) begin
        if (bus.cache_hit) begin
          if (!write_q) rdata_q <= bus.cache_rdata;
          if (hit_q != CNT_MAX) hit_q <= hit_q + CNT_W'(1);
        end else if (miss_q != CNT_MAX) begin
          miss_q <= miss_q + CNT_W'(1);
        end
      end
      if (state == S_FILL && bus.sram_ready) rdata_q <= fill_word;
    end
  end

  always_comb begin
    state_nx       = state;
    ready_c        = 1'b0;
    cache_r_en_c   = 1'b0;
    cache_w_en_c   = 1'b0;
    cache_upd_en_c = 1'b0;
    cache_inv_c    = 1'b0;
    sram_req_c     = 1'b0;
    sram_we_c      = 1'b0;
    sram_addr_c    = addr_q;
    case (state)
      S_IDLE: begin
        ready_c = ~req;
        if (req) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        cache_r_en_c = 1'b1;
        if (write_q) begin
          state_nx = S_WRITE;
          if (bus.cache_hit) begin
            if (WRITE_POLICY == 1) cache_upd_en_c = 1'b1;
            else                   cache_inv_c    = 1'b1;
          end
        end else begin
          state_nx = bus.cache_hit ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        sram_req_c  = 1'b1;
        sram_addr_c = addr_q & ~OFF_MASK;
        if (bus.sram_ready) begin
          cache_w_en_c = 1'b1;
          state_nx     = S_DONE;
        end
      end
      S_WRITE: begin
        sram_req_c = 1'b1;
        sram_we_c  = 1'b1;
        if (bus.sram_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        ready_c  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ready is held low for as long as reset is applied
  assign bus.ready            = rst & ready_c;
  assign bus.rdata            = rdata_q;
  assign bus.hit_cnt          = hit_q;
  assign bus.miss_cnt         = miss_q;
  assign bus.sram_req         = sram_req_c;
  assign bus.sram_we          = sram_we_c;
  assign bus.sram_addr        = sram_addr_c;
  assign bus.sram_wdata       = wdata_q;
  assign bus.cache_addr       = addr_q;
  assign bus.cache_r_en       = cache_r_en_c;
  assign bus.cache_w_en       = cache_w_en_c;
  assign bus.cache_fill       = bus.sram_rdata;
  assign bus.cache_upd_en     = cache_upd_en_c;
  assign bus.cache_wdata      = wdata_q;
  assign bus.cache_invalidate = cache_inv_c;
endmodule

// File: tb/tb_cache_ctrl_param.sv
// Scoreboard bench for cache_ctrl_param: a reference model predicts hit/miss, data,
// counters and latency per request; a monitor checks them when ready completes a request.
module tb_cache_ctrl_param;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int LW         = 2;
  localparam int WP         = 0;
  localparam int CNT_W      = 4;
  localparam int LINE_BYTES = LW * DATA_W / 8;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LW), .CNT_W(CNT_W)) bus ();

  cache_ctrl_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LW), .WRITE_POLICY(WP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit               rd;
    logic [31:0]      rdata;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] misses;
    int               acc;
    int               lat;
    int               fills;
    int               invals;
    int               upds;
  } exp_t;

  exp_t sb[$];

  // reference model: memory contents, valid lines, statistics
  logic [31:0]      ref_mem   [logic [31:0]];
  bit               ref_valid [logic [31:0]];
  logic [CNT_W-1:0] ref_hits   = '0;
  logic [CNT_W-1:0] ref_misses = '0;

  // environment models: SRAM contents and the cache array
  logic [31:0]            sram_mem  [logic [31:0]];
  logic [LW*DATA_W-1:0]   cache_arr [logic [31:0]];

  logic [31:0] exp_saddr  = '0;
  logic [31:0] exp_swdata = '0;
  bit          exp_swe    = 1'b0;
  bit          exp_sactive = 1'b0;
  int          sram_lat   = 1;
  int          fills_seen = 0;
  int          invals_seen = 0;
  int          upds_seen  = 0;
  int          done_cnt   = 0;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a % LINE_BYTES) / 4);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : mem_default(a);
  endfunction

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // SRAM and cache-array responder
  initial begin
    int                   cnt;
    logic [31:0]          ln_addr;
    logic [LW*DATA_W-1:0] ln;
    int                   w;
    cnt = 0;
    bus.sram_ready  = 1'b0;
    bus.sram_rdata  = '0;
    bus.cache_hit   = 1'b0;
    bus.cache_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0;
        bus.sram_ready = 1'b0;
        bus.cache_hit  = 1'b0;
      end else begin
        if (bus.cache_r_en) begin
          ln_addr = line_of(bus.cache_addr);
          w = word_of(bus.cache_addr);
          bus.cache_hit = cache_arr.exists(ln_addr);
          if (cache_arr.exists(ln_addr)) begin
            ln = cache_arr[ln_addr];
            bus.cache_rdata = ln[w*DATA_W +: DATA_W];
          end else begin
            bus.cache_rdata = $urandom;
          end
        end else begin
          bus.cache_hit   = 1'($urandom_range(0, 1));
          bus.cache_rdata = $urandom;
        end
        if (bus.sram_req) begin
          cnt++;
          if (!exp_sactive) check("sram_req_unexpected", 64'(bus.sram_req), 64'd0);
          else begin
            check("sram_addr", 64'(bus.sram_addr), 64'(exp_saddr));
            check("sram_we", 64'(bus.sram_we), 64'(exp_swe));
            if (exp_swe) check("sram_wdata", 64'(bus.sram_wdata), 64'(exp_swdata));
          end
          bus.sram_ready = (cnt == sram_lat);
          for (int i = 0; i < LW; i++) ln[i*DATA_W +: DATA_W] = sram_rd(bus.sram_addr + 32'(4 * i));
          bus.sram_rdata = ln;
        end else begin
          cnt = 0;
          bus.sram_ready = 1'($urandom_range(0, 1));
          for (int i = 0; i < LW; i++) ln[i*DATA_W +: DATA_W] = $urandom;
          bus.sram_rdata = ln;
        end
        #1;
        if (bus.cache_w_en) begin
          fills_seen++;
          cache_arr[line_of(bus.cache_addr)] = bus.cache_fill;
        end
        if (bus.cache_invalidate) begin
          invals_seen++;
          cache_arr.delete(line_of(bus.cache_addr));
        end
        if (bus.cache_upd_en) begin
          upds_seen++;
          ln_addr = line_of(bus.cache_addr);
          ln = cache_arr.exists(ln_addr) ? cache_arr[ln_addr] : '0;
          ln[word_of(bus.cache_addr)*DATA_W +: DATA_W] = bus.cache_wdata;
          cache_arr[ln_addr] = ln;
        end
        if (bus.sram_req && bus.sram_we && bus.sram_ready) sram_mem[bus.sram_addr] = bus.sram_wdata;
      end
    end
  end

  // monitor: pops one expectation per completed request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("latency", 64'(cyc - e.acc), 64'(e.lat));
        if (e.rd) check("rdata", 64'(bus.rdata), 64'(e.rdata));
        check("hit_cnt", 64'(bus.hit_cnt), 64'(e.hits));
        check("miss_cnt", 64'(bus.miss_cnt), 64'(e.misses));
        check("fill_pulses", 64'(fills_seen), 64'(e.fills));
        check("inval_pulses", 64'(invals_seen), 64'(e.invals));
        check("upd_pulses", 64'(upds_seen), 64'(e.upds));
        fills_seen  = 0;
        invals_seen = 0;
        upds_seen   = 0;
        exp_sactive = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int nlat);
    exp_t        e;
    logic [31:0] ln_addr;
    bit          hit;
    int          d0;
    int          t;
    ln_addr  = line_of(a);
    hit      = ref_valid.exists(ln_addr);
    e.rd     = rd;
    e.rdata  = '0;
    e.fills  = 0;
    e.invals = 0;
    e.upds   = 0;
    if (hit) ref_hits   = (ref_hits == CMAX) ? CMAX : ref_hits + 1'b1;
    else     ref_misses = (ref_misses == CMAX) ? CMAX : ref_misses + 1'b1;
    if (rd) begin
      e.rdata = ref_rd(a);
      if (!hit) begin
        ref_valid[ln_addr] = 1'b1;
        e.fills = 1;
      end
      e.lat     = hit ? 1 : nlat + 1;
      exp_saddr = ln_addr;
      exp_swe   = 1'b0;
    end else begin
      ref_mem[a] = wd;
      if (hit) begin
        if (WP == 0) begin
          ref_valid.delete(ln_addr);
          e.invals = 1;
        end else begin
          e.upds = 1;
        end
      end
      e.lat      = nlat + 1;
      exp_saddr  = a;
      exp_swe    = 1'b1;
      exp_swdata = wd;
    end
    exp_sactive = !(rd && hit);
    sram_lat    = nlat;
    e.hits      = ref_hits;
    e.misses    = ref_misses;
    bus.addr     = a;
    bus.wdata    = wd;
    bus.mem_r_en = rd;
    bus.mem_w_en = wr;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout: no ready for addr %0h after %0d cycles, required within %0d", a, t, e.lat);
      summary();
      $finish;
    end
  endtask

  initial begin
    bit          rd;
    bit          wr;
    logic [31:0] a;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_sram_req", 64'(bus.sram_req), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_hit_cnt", 64'(bus.hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(bus.miss_cnt), 64'd0);
    check("rst_cache_r_en", 64'(bus.cache_r_en), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("idle_ready", 64'(bus.ready), 64'd1);
    check("idle_sram_req", 64'(bus.sram_req), 64'd0);

    sram_mem[32'h100] = 32'h11111111;
    sram_mem[32'h104] = 32'h22222222;
    ref_mem[32'h100]  = 32'h11111111;
    ref_mem[32'h104]  = 32'h22222222;

    do_txn(1'b1, 1'b0, 32'h104, 32'h0, 4);
    do_txn(1'b1, 1'b0, 32'h104, 32'h0, 1);
    do_txn(1'b0, 1'b1, 32'h104, 32'h55, 2);
    do_txn(1'b1, 1'b0, 32'h104, 32'h0, 1);
    do_txn(1'b1, 1'b1, 32'h108, 32'hAAAA, 3);
    do_txn(1'b0, 1'b1, 32'h130, 32'h77, 1);

    repeat (150) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
      do_txn(rd, wr, a, $urandom, int'($urandom_range(1, 4)));
    end
    check("hit_cnt_final", 64'(bus.hit_cnt), 64'(ref_hits));
    check("miss_cnt_final", 64'(bus.miss_cnt), 64'(ref_misses));

    // reset while a line fill is outstanding
    exp_sactive  = 1'b1;
    exp_saddr    = 32'h800;
    exp_swe      = 1'b0;
    sram_lat     = 1000;
    bus.addr     = 32'h804;
    bus.mem_r_en = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_r_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3;
    check("fill_req_before_rst", 64'(bus.sram_req), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_sram_req", 64'(bus.sram_req), 64'd0);
    check("abort_rdata", 64'(bus.rdata), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd0);
    check("abort_hit_cnt", 64'(bus.hit_cnt), 64'd0);
    check("abort_cache_w_en", 64'(bus.cache_w_en), 64'd0);
    ref_hits    = '0;
    ref_misses  = '0;
    exp_sactive = 1'b0;
    fills_seen  = 0;
    invals_seen = 0;
    upds_seen   = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("post_abort_ready", 64'(bus.ready), 64'd1);
    do_txn(1'b1, 1'b0, 32'h804, 32'h0, 2);

    summary();
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1);
  end
endmodule
